// File: rtl/blkmem_pkg.sv
// Shared types and constants for the block-RAM responder.
// Holds the latency encodings, the 0->1 latency clamp and the record that
// one read-pipeline stage carries (valid, data, parity).
package blkmem_pkg;

    localparam logic [1:0] LAT_1 = 2'd1;
    localparam logic [1:0] LAT_2 = 2'd2;
    localparam logic [1:0] LAT_3 = 2'd3;

    // Widest data word a pipeline stage can carry; narrower words are zero-extended.
    localparam int STAGE_DATA_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [STAGE_DATA_W-1:0] data;
        logic                    parity;
    } stage_t;

    // A requested latency of 0 is not meaningful, so it runs as latency 1.
    function automatic logic [1:0] clamp_lat(input logic [1:0] lat);
        return (lat == 2'd0) ? LAT_1 : lat;
    endfunction

endpackage

// File: rtl/blkmem_array.sv
// Raw single-port synchronous-read array, read-first.
// Kept apart from the latency pipeline so the RAM infers cleanly.
// Build option BLKMEM_PARITY_EN: each word stores an even-parity bit, and
// inj_flip (normally 0, driven only by a hierarchical force in test) inverts
// the stored parity of a write whose wdata[0] is set.
module blkmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rpar
);

`ifdef BLKMEM_PARITY_EN
    logic [DATA_W:0] mem [0:(1<<ADDR_W)-1];
    logic            inj_flip;
    logic            wpar;

    assign inj_flip = 1'b0;
    assign wpar     = (^wdata) ^ (inj_flip & wdata[0]);

    // Write data+parity, or capture the old word on a read (read-first).
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= {wpar, wdata};
            else    {rpar, rdata} <= mem[addr];
        end
    end
`else
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    assign rpar = 1'b0;

    // Write the word, or capture it on a read (read-first).
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
`endif

endmodule

// File: rtl/blkmem_responder.sv
// Block-RAM responder: memory side of the en/valid read handshake.
// Handshake: a request is taken on every clock edge where en = 1 (there is no
// back-pressure); a read taken at an edge returns exactly lat_q cycles later as
// a one-cycle rvalid pulse with rdata, in request order; writes never respond.
// lat_q reloads from read_latency only while busy = 0, so a latency change
// never reorders or splits in-flight reads. Stage 1 is the array's own output
// register; stages 2..MAX_LAT shift unconditionally. A stage past lat_q has
// already been delivered, so its valid bit is not propagated further.
// MAX_LAT is 3 here (read_latency is two bits).
// Build option BLKMEM_PARITY_EN adds stored parity and the perr output.
module blkmem_responder
    import blkmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MAX_LAT = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        read_latency,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              perr
);

    logic [DATA_W-1:0] arr_rdata;
    logic              arr_rpar;

    logic              v1_q;
    stage_t            sh_q [2:MAX_LAT];
    logic [1:0]        lat_q;
    logic              busy_q;

    stage_t            st [1:MAX_LAT];
    logic [1:0]        lat_n;
    logic [MAX_LAT:1]  vn;
    logic              busy_n;
    stage_t            sel;

    blkmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .en    (en),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (arr_rdata),
        .rpar  (arr_rpar)
    );

    // Uniform view of all stages: stage 1 is the array register plus its valid bit.
    always_comb begin
        st[1].valid  = v1_q;
        st[1].data   = STAGE_DATA_W'(arr_rdata);
        st[1].parity = arr_rpar;
        for (int k = 2; k <= MAX_LAT; k++) st[k] = sh_q[k];
    end

    // Next latency, next valid bits and next busy.
    always_comb begin
        lat_n  = busy_q ? lat_q : clamp_lat(read_latency);
        vn     = '0;
        vn[1]  = en & ~we;
        for (int k = 2; k <= MAX_LAT; k++)
            vn[k] = st[k-1].valid && ((k - 1) < int'(lat_q));
        busy_n = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++)
            if (k <= int'(lat_n)) busy_n = busy_n | vn[k];
    end

    // Pipeline, latency and busy registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            lat_q  <= LAT_1;
            busy_q <= 1'b0;
            for (int k = 2; k <= MAX_LAT; k++) sh_q[k] <= '0;
        end else begin
            v1_q   <= vn[1];
            lat_q  <= lat_n;
            busy_q <= busy_n;
            for (int k = 2; k <= MAX_LAT; k++) begin
                sh_q[k].valid  <= vn[k];
                sh_q[k].data   <= st[k-1].data;
                sh_q[k].parity <= st[k-1].parity;
            end
        end
    end

    // Output stage selected by the effective latency.
    always_comb begin
        case (lat_q)
            LAT_1:   sel = st[1];
            LAT_2:   sel = st[2];
            LAT_3:   sel = st[3];
            default: sel = st[1];
        endcase
    end

    assign rvalid = sel.valid;
    assign rdata  = sel.valid ? sel.data[DATA_W-1:0] : '0;
    assign busy   = busy_q;

`ifdef BLKMEM_PARITY_EN
    assign perr = sel.valid & ((^sel.data[DATA_W-1:0]) != sel.parity);
`else
    logic unused_parity;
    assign unused_parity = sel.parity;
    assign perr          = 1'b0;
`endif

endmodule

// File: tb/tb_blkmem_responder.sv
// Bench for blkmem_responder: driver tasks feed a reference model (memory
// array plus per-read due cycle), a negedge monitor compares every response
// and the busy flag against the expected queues.
module tb_blkmem_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  read_latency = 2'd1;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        perr;

    blkmem_responder #(.ADDR_W(8), .DATA_W(32), .MAX_LAT(3)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .read_latency (read_latency),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .busy         (busy),
        .perr         (perr)
    );

    // Clock and edge counter: cyc = number of rising edges so far.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [31:0] mem_m  [256];
    logic        pbad_m [256];
    logic [31:0] exp_q [$];
    int          due_q [$];
    logic        perr_q [$];
    int          mlat = 1;
    int          last_due = -1;
    bit          mon_en = 1'b0;
    bit          inj_now = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One request cycle; inputs change just after the falling edge and are
    // taken at the next rising edge (edge number cyc+1).
    task automatic drive(input logic e, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [1:0] rl, input logic r);
        @(negedge clk);
        #1;
        rstn = r; en = e; we = w; addr = a; wdata = d; read_latency = rl;
        if (!r) begin
            exp_q.delete(); due_q.delete(); perr_q.delete();
            mlat = 1;
            last_due = -1;
        end else begin
            // Nothing outstanding in the current cycle: latency may reload.
            if (last_due < cyc) mlat = (rl == 2'd0) ? 1 : int'(rl);
            if (e && w) begin
                mem_m[a]  = d;
                pbad_m[a] = inj_now & d[0];
            end else if (e) begin
                exp_q.push_back(mem_m[a]);
                perr_q.push_back(pbad_m[a]);
                last_due = (cyc + 1) + mlat - 1;
                due_q.push_back(last_due);
            end
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [1:0] rl);
        drive(1'b1, 1'b0, a, $urandom, rl, 1'b1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [1:0] rl);
        drive(1'b1, 1'b1, a, d, rl, 1'b1);
    endtask

    task automatic idle(input int n, input logic [1:0] rl);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom), $urandom, rl, 1'b1);
    endtask

    // Monitor: busy every cycle, and each rvalid against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'b0, busy}, {31'b0, (last_due >= cyc)});
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h expected no response (cycle %0d)", rdata, cyc);
                end else begin
                    check("rdata", rdata, exp_q.pop_front());
                    check("rvalid_cycle", cyc, due_q.pop_front());
                    check("perr", {31'b0, perr}, {31'b0, perr_q.pop_front()});
                end
            end else begin
                check("perr_idle", {31'b0, perr}, 32'd0);
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_rvalid: got rvalid=0 expected data %h due cycle %0d (cycle %0d)", exp_q[0], due_q[0], cyc);
                    void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(perr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] rl;
        int         r;

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0, 32'd0, 2'd1, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_perr", {31'b0, perr}, 32'd0);
        mon_en = 1'b1;

        // Preload every word so any address can be read.
        for (int i = 0; i < 256; i++) begin
            if (i < 4)          wr(8'(i), 32'(i), 2'd1);
            else if (i == 5)    wr(8'(i), 32'h11, 2'd1);
            else if (i == 'h10) wr(8'(i), 32'hA5A5_0001, 2'd1);
            else                wr(8'(i), $urandom, 2'd1);
        end
        idle(2, 2'd1);

        // Latency 1 single read.
        rd(8'h10, 2'd1);
        idle(3, 2'd1);

        // Latency 3, four back-to-back reads.
        for (int i = 0; i < 4; i++) rd(8'(i), 2'd3);
        idle(5, 2'd3);

        // Latency 0 runs as latency 1.
        rd(8'h10, 2'd0);
        idle(3, 2'd0);

        // Latency change while busy is held off until the pipeline drains.
        rd(8'd1, 2'd2);
        idle(4, 2'd3);
        rd(8'd2, 2'd3);
        idle(5, 2'd3);

        // Read-first: write right behind a read does not disturb it.
        rd(8'd5, 2'd3);
        wr(8'd5, 32'h22, 2'd3);
        idle(4, 2'd3);
        rd(8'd5, 2'd3);
        idle(5, 2'd3);

        // Reset with two reads in flight drops them.
        rd(8'd0, 2'd3);
        rd(8'd1, 2'd3);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 2'd3, 1'b0);
        idle(1, 2'd3);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        idle(5, 2'd3);

`ifdef BLKMEM_PARITY_EN
        // Parity injection: stored parity inverted on an odd-data write.
        inj_now = 1'b1;
        force dut.u_array.inj_flip = 1'b1;
        wr(8'd7, 32'h0000_0003, 2'd2);
        release dut.u_array.inj_flip;
        inj_now = 1'b0;
        idle(1, 2'd2);
        rd(8'd7, 2'd2);
        idle(4, 2'd2);
        wr(8'd7, 32'h0000_0005, 2'd2);
        rd(8'd7, 2'd2);
        idle(4, 2'd2);
`endif

        // Randomized traffic with occasional latency reprogramming.
        rl = 2'd1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) rl = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 20)      idle(1, rl);
            else if (r < 45) wr(8'($urandom_range(0, 255)), $urandom, rl);
            else             rd(8'($urandom_range(0, 255)), rl);
        end
        idle(8, 2'd1);

        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blkmem_responder.md
Name: blkmem_responder

Overview:
Synthesizable single-port block-RAM responder: the memory side of the en/valid read handshake.
- Accepts read and write requests on en/we.
- Returns read data with a runtime-selectable latency of 1..3 cycles, qualified by rvalid.
- Used as the memory model and on-chip buffer behind our read-side latency controllers, so their latency programming can be checked against a real pipeline.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W words
DATA_W, 32, data word width
MAX_LAT, 3, deepest read pipeline supported; read_latency is a 2-bit port, so MAX_LAT is at most 3

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
en  in  1  request strobe, one request per cycle
we  in  1  1 = write, 0 = read; qualified by en
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
read_latency  in  2  requested read latency in cycles
rdata  out  DATA_W  read data, valid only while rvalid = 1
rvalid  out  1  one-cycle pulse per accepted read
busy  out  1  high while any read is in flight
perr  out  1  parity error flag, pulses with rvalid (optional feature)

Behaviour:
- Reset (rstn = 0 at a clock edge):
  - rdata = 0, rvalid = 0, busy = 0, perr = 0.
  - Pipeline valid bits cleared; lat_q = 1.
  - Memory array contents are not reset.
  - Reads in flight when reset is asserted are dropped; no rvalid is produced for them.
- Effective latency:
  - lat_q is a registered copy of read_latency, loaded only on a cycle where busy = 0.
  - A value of 0 is loaded as 1.
  - Changes to read_latency while busy = 1 are ignored until the pipeline drains.
  - A read accepted in the same cycle that lat_q loads uses the newly loaded value.
- Write (en = 1, we = 1): mem[addr] <= wdata at that edge. No response is generated.
- Read (en = 1, we = 0):
  - Array read at the acceptance edge into stage 1: data plus valid bit.
  - Stages 2..MAX_LAT form a shift register advancing every cycle with no stall.
  - rdata and rvalid are driven from stage lat_q. A read accepted at edge N has rvalid = 1 in cycle N + lat_q.
- Back-to-back reads: one read per cycle sustained; responses return in order, one per cycle.
- Read/write collision: a read of an address written in the same cycle is impossible on a single port. A write issued while reads are in flight does not alter data already captured in stage 1 or later (read-first).
- busy = OR of the valid bits in stages 1..lat_q. It is registered and goes low the cycle after the last rvalid.
- en = 0: no new request enters; in-flight reads drain normally.
- Out-of-range addr cannot occur (full 2**ADDR_W decode).

Optional Feature:
BLKMEM_PARITY_EN
- Defined:
  - Each array word gains one even-parity bit computed from wdata on write.
  - The parity bit travels through the pipeline with the data.
  - At output, perr = rvalid AND (recomputed parity != stored parity).
  - A test-only injection path, gated by the same macro, forces stored parity inverted when wdata[0] and we are set under hierarchical force.
- Undefined: no parity storage; perr is tied to 0.

Decomposition:
- Package blkmem_pkg:
  - Latency encodings LAT_1 = 2'd1, LAT_2 = 2'd2, LAT_3 = 2'd3, and the clamp-0-to-1 rule as a constant function.
  - The pipeline stage record type (valid, data, parity).
- Sub-module blkmem_array: the raw sync-read array with its parity bit. It keeps the RAM inference separate from the latency pipeline.

Test Plan:
- Reset, then write 0xA5A5_0001 to addr 0x10, read 0x10 with read_latency = 1 -> rvalid in cycle N+1 with rdata = 0xA5A5_0001; busy high for exactly 1 cycle.
- read_latency = 3, reads of addr 0..3 on consecutive cycles (preloaded 0..3) -> rvalid high in cycles N+3..N+6 carrying 0,1,2,3 in order.
- read_latency = 0, read addr 0x10 -> behaves as latency 1.
- read_latency = 2, read issued, then read_latency changed to 3 on the next cycle -> first response still at +2; a read issued after busy falls returns at +3.
- Read addr 5 (holding 0x11), write 0x22 to addr 5 on the next cycle with latency 3 -> rvalid carries 0x11; a later read returns 0x22.
- Reset asserted while 2 reads are in flight -> no rvalid afterwards; rdata = 0, busy = 0. With BLKMEM_PARITY_EN, inject a parity flip -> perr = 1 coincident with rvalid.
